// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one frame-buffer BRAM port between NUM_REQ external
// requesters and an internal range-fill engine (index NUM_REQ). Round-robin
// arbitration with a lock for atomic read-modify-write. Read data comes back
// one cycle after the read beat, tagged with the requester index.
module fb_port_arbiter #(
    parameter int ADDR_BITS = 14,
    parameter int NUM_REQ   = 3,
    parameter int IDW       = $clog2(NUM_REQ + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_BITS-1:0]  req_addr,
    input  logic [NUM_REQ*8-1:0]          req_wdata,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic                          rd_valid,
    output logic [IDW-1:0]                rd_id,
    output logic [7:0]                    rd_data,
    input  logic                          fill_start,
    input  logic [ADDR_BITS-1:0]          fill_base,
    input  logic [ADDR_BITS-1:0]          fill_len,
    input  logic [7:0]                    fill_value,
    output logic                          fill_busy,
    output logic                          fill_done,
    output logic [ADDR_BITS-1:0]          fb_addr,
    output logic [7:0]                    fb_wdata,
    output logic                          fb_we,
    input  logic [7:0]                    fb_rdata,
    output logic                          busy
);

    typedef enum logic {F_IDLE, F_RUN} fill_state_t;

    localparam logic [IDW-1:0] FILL_IDX = IDW'(NUM_REQ);

    fill_state_t          fill_state_reg;
    logic [ADDR_BITS-1:0] fill_addr_reg;
    logic [ADDR_BITS-1:0] fill_rem_reg;
    logic [7:0]           fill_value_reg;

    logic [IDW-1:0]       last_reg;
    logic [IDW-1:0]       lock_owner_reg;
    logic                 lock_active_reg;

    logic [NUM_REQ:0]     cand;
    logic                 owner_valid;
    logic                 win_found;
    logic [IDW-1:0]       win_idx;
    logic                 win_we;
    logic                 win_lock;
    logic                 win_ext;
    int                   rr_idx;

    logic [ADDR_BITS-1:0] addr_arr  [NUM_REQ];
    logic [7:0]           wdata_arr [NUM_REQ];

    // Unpack requester buses and form the one-hot grant from the winner index
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*ADDR_BITS +: ADDR_BITS];
            assign wdata_arr[gi] = req_wdata[gi*8 +: 8];
            assign req_grant[gi] = win_found && (win_idx == IDW'(gi));
        end
    endgenerate

    assign rd_data = fb_rdata;
    assign busy    = (|req_valid) | lock_active_reg | fill_busy | rd_valid;

    // Pick the winner: a still-valid lock owner, otherwise round-robin from last+1
    always_comb begin
        cand        = {fill_busy, req_valid};
        owner_valid = 1'b0;
        win_found   = 1'b0;
        win_idx     = '0;
        rr_idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (lock_owner_reg == IDW'(i) && req_valid[i]) owner_valid = 1'b1;
        end
        if (lock_active_reg && owner_valid) begin
            win_found = 1'b1;
            win_idx   = lock_owner_reg;
        end else begin
            for (int k = 1; k <= NUM_REQ + 1; k++) begin
                rr_idx = (int'(last_reg) + k) % (NUM_REQ + 1);
                if (!win_found && cand[rr_idx]) begin
                    win_found = 1'b1;
                    win_idx   = IDW'(rr_idx);
                end
            end
        end
    end

    // Drive the BRAM port from the winner; idle port is all zeros
    always_comb begin
        fb_addr  = '0;
        fb_wdata = '0;
        fb_we    = 1'b0;
        win_we   = 1'b1;
        win_lock = 1'b0;
        win_ext  = 1'b0;
        if (win_found) begin
            if (win_idx == FILL_IDX) begin
                fb_addr  = fill_addr_reg;
                fb_wdata = fill_value_reg;
                fb_we    = 1'b1;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (win_idx == IDW'(i)) begin
                        fb_addr  = addr_arr[i];
                        fb_wdata = wdata_arr[i];
                        fb_we    = req_we[i];
                        win_we   = req_we[i];
                        win_lock = req_lock[i];
                        win_ext  = 1'b1;
                    end
                end
            end
        end
    end

    // Round-robin pointer and lock ownership; an owner dropping valid frees the lock
    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg        <= FILL_IDX;
            lock_owner_reg  <= '0;
            lock_active_reg <= 1'b0;
        end else begin
            if (win_found) last_reg <= win_idx;
            if (win_found && win_ext && win_lock) begin
                lock_active_reg <= 1'b1;
                lock_owner_reg  <= win_idx;
            end else if (lock_active_reg &&
                         (!owner_valid || (win_found && win_idx == lock_owner_reg))) begin
                lock_active_reg <= 1'b0;
            end
        end
    end

    // Tag read beats so the returning BRAM byte carries its owner next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_id    <= '0;
        end else if (win_found && !win_we) begin
            rd_valid <= 1'b1;
            rd_id    <= win_idx;
        end else begin
            rd_valid <= 1'b0;
        end
    end

    // Fill engine: latch the job on start, then one write per accepted fill beat
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_state_reg <= F_IDLE;
            fill_busy      <= 1'b0;
            fill_done      <= 1'b0;
            fill_addr_reg  <= '0;
            fill_rem_reg   <= '0;
            fill_value_reg <= '0;
        end else begin
            fill_done <= 1'b0;
            case (fill_state_reg)
                F_IDLE: begin
                    if (fill_start) begin
                        fill_addr_reg  <= fill_base;
                        fill_rem_reg   <= fill_len;
                        fill_value_reg <= fill_value;
                        if (fill_len == '0) begin
                            fill_done <= 1'b1;
                        end else begin
                            fill_state_reg <= F_RUN;
                            fill_busy      <= 1'b1;
                        end
                    end
                end
                F_RUN: begin
                    if (win_found && win_idx == FILL_IDX) begin
                        fill_addr_reg <= fill_addr_reg + ADDR_BITS'(1);
                        fill_rem_reg  <= fill_rem_reg - ADDR_BITS'(1);
                        if (fill_rem_reg == ADDR_BITS'(1)) begin
                            fill_state_reg <= F_IDLE;
                            fill_busy      <= 1'b0;
                            fill_done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    fill_state_reg <= F_IDLE;
                    fill_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter.
module tb_fb_port_arbiter;
    localparam int AB  = 14;
    localparam int NR  = 3;
    localparam int IDW = $clog2(NR + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid, req_we, req_lock;
    logic [NR*AB-1:0] req_addr;
    logic [NR*8-1:0]  req_wdata;
    logic [NR-1:0]    req_grant;
    logic             rd_valid;
    logic [IDW-1:0]   rd_id;
    logic [7:0]       rd_data;
    logic             fill_start;
    logic [AB-1:0]    fill_base, fill_len;
    logic [7:0]       fill_value;
    logic             fill_busy, fill_done;
    logic [AB-1:0]    fb_addr;
    logic [7:0]       fb_wdata;
    logic             fb_we;
    logic [7:0]       fb_rdata;
    logic             busy;

    int checks = 0;
    int errors = 0;

    fb_port_arbiter #(.ADDR_BITS(AB), .NUM_REQ(NR)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(req_grant),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we),
        .fb_rdata(fb_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic clear_inputs();
        req_valid  = '0;
        req_we     = '0;
        req_lock   = '0;
        req_addr   = '0;
        req_wdata  = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_value = '0;
        fb_rdata   = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [AB-1:0] a, input logic [7:0] d);
        req_valid[i]        = v;
        req_we[i]           = we;
        req_lock[i]         = lk;
        req_addr[i*AB +: AB] = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AB-1:0] fill_exp [4];
        logic [NR-1:0] rr_exp [6];
        int cyc, done_cyc, busy_cnt, fill_beats, req0_beats, viol, prev_w, w, dones, writes;

        fill_exp = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        rr_exp   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset values
        do_reset();
        @(negedge clk);
        check_val("rst_grant", 32'(req_grant), 0);
        check_val("rst_rd_valid", 32'(rd_valid), 0);
        check_val("rst_rd_id", 32'(rd_id), 0);
        check_val("rst_fill_busy", 32'(fill_busy), 0);
        check_val("rst_fill_done", 32'(fill_done), 0);
        check_val("rst_fb_we", 32'(fb_we), 0);
        check_val("rst_fb_addr", 32'(fb_addr), 0);
        check_val("rst_fb_wdata", 32'(fb_wdata), 0);
        check_val("rst_busy", 32'(busy), 0);

        // Single requester write
        next_cycle();
        set_req(1, 1'b1, 1'b1, 1'b0, 14'h0123, 8'hA5);
        @(negedge clk);
        check_val("single_grant", 32'(req_grant), 32'b010);
        check_val("single_we", 32'(fb_we), 1);
        check_val("single_addr", 32'(fb_addr), 32'h0123);
        check_val("single_wdata", 32'(fb_wdata), 32'hA5);
        check_val("single_busy", 32'(busy), 1);

        // Round-robin with all three valid
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 1'b0, AB'(i), 8'(i));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val($sformatf("rr_grant_%0d", k), 32'(req_grant), 32'(rr_exp[k]));
            next_cycle();
        end
        clear_inputs();

        // One req1 beat so requester 2 is next in line
        set_req(1, 1'b1, 1'b1, 1'b0, 14'h0001, 8'h01);
        next_cycle();
        clear_inputs();

        // Lock RMW by requester 2 with requester 0 competing
        set_req(2, 1'b1, 1'b0, 1'b1, 14'h0010, 8'h00);
        set_req(0, 1'b1, 1'b1, 1'b0, 14'h0200, 8'h11);
        @(negedge clk);
        check_val("lock_rd_grant", 32'(req_grant), 32'b100);
        check_val("lock_rd_we", 32'(fb_we), 0);
        check_val("lock_rd_addr", 32'(fb_addr), 32'h0010);
        next_cycle();
        set_req(2, 1'b1, 1'b1, 1'b0, 14'h0010, 8'h3C);
        fb_rdata = 8'h7E;
        @(negedge clk);
        check_val("lock_wr_grant", 32'(req_grant), 32'b100);
        check_val("lock_wr_we", 32'(fb_we), 1);
        check_val("lock_wr_wdata", 32'(fb_wdata), 32'h3C);
        check_val("lock_rd_valid", 32'(rd_valid), 1);
        check_val("lock_rd_id", 32'(rd_id), 2);
        check_val("lock_rd_data", 32'(rd_data), 32'h7E);
        next_cycle();
        set_req(2, 1'b0, 1'b0, 1'b0, 14'h0000, 8'h00);
        @(negedge clk);
        check_val("lock_after_grant", 32'(req_grant), 32'b001);
        check_val("lock_after_rd_valid", 32'(rd_valid), 0);
        next_cycle();
        clear_inputs();

        // Lock released by owner dropping valid; arbitration runs that cycle
        set_req(1, 1'b1, 1'b0, 1'b1, 14'h0020, 8'h00);
        set_req(0, 1'b1, 1'b1, 1'b0, 14'h0200, 8'h22);
        @(negedge clk);
        check_val("drop_lock_grant", 32'(req_grant), 32'b010);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 1'b0, 14'h0000, 8'h00);
        @(negedge clk);
        check_val("drop_release_grant", 32'(req_grant), 32'b001);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Fill with address wrap
        fill_base  = 14'h3FFE;
        fill_len   = 14'd4;
        fill_value = 8'h00;
        fill_start = 1'b1;
        @(negedge clk);
        check_val("fill_start_busy", 32'(fill_busy), 0);
        next_cycle();
        fill_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val($sformatf("fill_busy_%0d", k), 32'(fill_busy), 1);
            check_val($sformatf("fill_we_%0d", k), 32'(fb_we), 1);
            check_val($sformatf("fill_addr_%0d", k), 32'(fb_addr), 32'(fill_exp[k]));
            check_val($sformatf("fill_grant_%0d", k), 32'(req_grant), 0);
            next_cycle();
        end
        @(negedge clk);
        check_val("fill_done", 32'(fill_done), 1);
        check_val("fill_end_busy", 32'(fill_busy), 0);
        check_val("fill_end_we", 32'(fb_we), 0);
        next_cycle();
        @(negedge clk);
        check_val("fill_done_clear", 32'(fill_done), 0);
        next_cycle();

        // Zero-length fill
        fill_len   = '0;
        fill_start = 1'b1;
        next_cycle();
        fill_start = 1'b0;
        @(negedge clk);
        check_val("len0_done", 32'(fill_done), 1);
        check_val("len0_busy", 32'(fill_busy), 0);
        check_val("len0_we", 32'(fb_we), 0);
        next_cycle();
        @(negedge clk);
        check_val("len0_done_clear", 32'(fill_done), 0);

        // Fill sharing with requester 0, plus an ignored restart
        do_reset();
        fill_base  = 14'h0100;
        fill_len   = 14'd1000;
        fill_value = 8'h5A;
        fill_start = 1'b1;
        next_cycle();
        fill_start = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b0, 14'h0200, 8'h33);
        done_cyc = 0; busy_cnt = 0; fill_beats = 0; req0_beats = 0; viol = 0; prev_w = -1;
        for (cyc = 1; cyc <= 2500; cyc++) begin
            fill_start = (cyc == 500);
            fill_len   = (cyc == 500) ? 14'd5 : 14'd1000;
            @(negedge clk);
            if (fill_done) begin
                done_cyc = cyc;
                break;
            end
            if (fill_busy) busy_cnt++;
            if (fill_busy && req_grant == 3'b000 && fb_we) fill_beats++;
            if (fill_busy && req_grant == 3'b001) req0_beats++;
            w = (req_grant == 3'b000 && fb_we) ? 3 : ((req_grant == 3'b001) ? 0 : 9);
            if (w == prev_w || w == 9) viol++;
            prev_w = w;
            next_cycle();
        end
        fill_start = 1'b0;
        check_val("share_done_cycle", 32'(done_cyc), 2001);
        check_val("share_busy_cycles", 32'(busy_cnt), 2000);
        check_val("share_fill_beats", 32'(fill_beats), 1000);
        check_val("share_req0_beats", 32'(req0_beats), 1000);
        check_val("share_alternation", 32'(viol), 0);
        next_cycle();
        @(negedge clk);
        check_val("share_done_once", 32'(fill_done), 0);
        clear_inputs();
        next_cycle();

        // Reset during RUN abandons the fill
        fill_base  = 14'h0020;
        fill_len   = 14'd10;
        fill_value = 8'h99;
        fill_start = 1'b1;
        next_cycle();
        fill_start = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        check_val("midrst_busy_before", 32'(fill_busy), 1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_val("midrst_fill_busy", 32'(fill_busy), 0);
        check_val("midrst_fill_done", 32'(fill_done), 0);
        check_val("midrst_rd_valid", 32'(rd_valid), 0);
        check_val("midrst_fb_we", 32'(fb_we), 0);
        check_val("midrst_fb_addr", 32'(fb_addr), 0);
        check_val("midrst_grant", 32'(req_grant), 0);
        dones = 0;
        writes = 0;
        for (int k = 0; k < 15; k++) begin
            next_cycle();
            @(negedge clk);
            if (fill_done) dones++;
            if (fb_we) writes++;
        end
        check_val("midrst_no_done", 32'(dones), 0);
        check_val("midrst_no_writes", 32'(writes), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
